// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Return-address prediction stack. A circular buffer of DEPTH
//               entries with a wrapping top pointer and a saturating count.
//               When full, a push silently recycles the oldest slot.
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Push,
    input  logic [AW-1:0] PushAddr,
    input  logic          Pop,
    input  logic          Flush,
    output logic [AW-1:0] TopAddr,
    output logic          TopValid,
    output logic          Full,
    output logic          Overflow,
    output logic          Underflow
);

    localparam int              c_PW        = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_DEPTH_CNT = (c_PW + 1)'(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ZERO  = '0;
    localparam logic [c_PW:0]   c_CNT_ZERO  = '0;

    logic [AW-1:0]   r_entries [DEPTH];
    logic [c_PW-1:0] r_topPtr;
    logic [c_PW:0]   r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic [c_PW-1:0] w_ptrNext;
    logic [c_PW:0]   w_cntNext;
    logic            w_wrEn;
    logic [c_PW-1:0] w_wrIdx;
    logic            w_ovfNext;
    logic            w_unfNext;
    logic            w_empty;
    logic            w_full;

    assign w_empty = (r_count == c_CNT_ZERO);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // Next pointer/count, storage write request and pulse causes; Flush wins.
    always_comb begin
        w_ptrNext = r_topPtr;
        w_cntNext = r_count;
        w_wrEn    = 1'b0;
        w_wrIdx   = r_topPtr;
        w_ovfNext = 1'b0;
        w_unfNext = 1'b0;
        if (Flush) begin
            w_ptrNext = c_PTR_ZERO;
            w_cntNext = c_CNT_ZERO;
        end else if (Push && Pop && !w_empty) begin
            // Return followed by call: replace the top entry in place.
            w_wrEn = 1'b1;
        end else if (Push) begin
            // Also covers Push+Pop on an empty stack (no underflow).
            w_ptrNext = r_topPtr + 1'b1;
            w_wrIdx   = r_topPtr + 1'b1;
            w_wrEn    = 1'b1;
            if (w_full) begin
                w_ovfNext = 1'b1;
            end else begin
                w_cntNext = r_count + 1'b1;
            end
        end else if (Pop) begin
            if (w_empty) begin
                w_unfNext = 1'b1;
            end else begin
                w_ptrNext = r_topPtr - 1'b1;
                w_cntNext = r_count - 1'b1;
            end
        end
    end

    // Pointer, count and status pulses; reset overrides all requests.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_topPtr    <= c_PTR_ZERO;
            r_count     <= c_CNT_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_topPtr    <= w_ptrNext;
            r_count     <= w_cntNext;
            r_overflow  <= w_ovfNext;
            r_underflow <= w_unfNext;
        end
    end

    // Entry storage: unreset, only the pushed slot is written.
    always_ff @(posedge Clk) begin
        if (Reset_n && w_wrEn) begin
            r_entries[w_wrIdx] <= PushAddr;
        end
    end

    // Stale contents after flush/reset are masked by the empty count.
    assign TopAddr   = w_empty ? '0 : r_entries[r_topPtr];
    assign TopValid  = !w_empty;
    assign Full      = w_full;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_addr_stack
// Description : Self-checking bench for return_addr_stack. A queue-based
//               reference model is compared on every falling edge; directed
//               sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Push;
    logic [AW-1:0] PushAddr;
    logic          Pop;
    logic          Flush;
    logic [AW-1:0] TopAddr;
    logic          TopValid;
    logic          Full;
    logic          Overflow;
    logic          Underflow;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    // Reference model: newest entry at the back of the queue.
    logic [AW-1:0] mq [$];
    bit            mOvf = 1'b0;
    bit            mUnf = 1'b0;

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Push      (Push),
        .PushAddr  (PushAddr),
        .Pop       (Pop),
        .Flush     (Flush),
        .TopAddr   (TopAddr),
        .TopValid  (TopValid),
        .Full      (Full),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update from the inputs present at each rising edge.
    always @(posedge Clk) begin
        mOvf = 1'b0;
        mUnf = 1'b0;
        if (!Reset_n || Flush) begin
            mq.delete();
        end else if (Push && Pop && mq.size() > 0) begin
            mq[mq.size()-1] = PushAddr;
        end else if (Push) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                mOvf = 1'b1;
            end
            mq.push_back(PushAddr);
        end else if (Pop) begin
            if (mq.size() == 0) mUnf = 1'b1;
            else void'(mq.pop_back());
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge Clk) begin
        if (checkEn) begin
            chk("model TopAddr",   TopAddr,   (mq.size() > 0) ? mq[$] : '0);
            chk("model TopValid",  AW'(TopValid),  AW'(mq.size() > 0));
            chk("model Full",      AW'(Full),      AW'(mq.size() == DEPTH));
            chk("model Overflow",  AW'(Overflow),  AW'(mOvf));
            chk("model Underflow", AW'(Underflow), AW'(mUnf));
        end
    end

    task automatic step(input logic push, input logic [AW-1:0] addr,
                        input logic pop, input logic flush, input logic rstn);
        Push     = push;
        PushAddr = addr;
        Pop      = pop;
        Flush    = flush;
        Reset_n  = rstn;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic doPush(input logic [AW-1:0] a); step(1'b1, a, 1'b0, 1'b0, 1'b1); endtask
    task automatic doPop();  step(1'b0, '0, 1'b1, 1'b0, 1'b1); endtask
    task automatic doIdle(); step(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n  = 1'b0;
        Push     = 1'b0;
        PushAddr = '0;
        Pop      = 1'b0;
        Flush    = 1'b0;

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        chk("reset TopAddr",   TopAddr,       32'h0);
        chk("reset TopValid",  AW'(TopValid), 32'h0);
        chk("reset Full",      AW'(Full),     32'h0);
        chk("reset Overflow",  AW'(Overflow), 32'h0);
        chk("reset Underflow", AW'(Underflow), 32'h0);

        // Basic push/pop
        doPush(32'h0040_0010);
        doPush(32'h0040_0020);
        chk("basic top2",   TopAddr,       32'h0040_0020);
        chk("basic valid2", AW'(TopValid), 32'h1);
        doPop();
        chk("basic top1", TopAddr, 32'h0040_0010);
        doPop();
        chk("basic empty valid", AW'(TopValid), 32'h0);
        chk("basic empty top",   TopAddr,       32'h0);

        // Fill past DEPTH: ninth push overwrites the oldest
        for (int i = 0; i < 8; i++) doPush(32'h100 + 32'(4 * i));
        chk("fill8 Full",     AW'(Full),     32'h1);
        chk("fill8 Overflow", AW'(Overflow), 32'h0);
        doPush(32'h120);
        chk("ovf pulse", AW'(Overflow), 32'h1);
        chk("ovf Full",  AW'(Full),     32'h1);
        chk("ovf top",   TopAddr,       32'h120);
        for (int i = 0; i < 8; i++) begin
            chk("drain popped value", TopAddr, 32'h120 - 32'(4 * i));
            doPop();
            if (i == 0) chk("ovf pulse ends", AW'(Overflow), 32'h0);
        end
        chk("drain empty", AW'(TopValid), 32'h0);

        // Underflow
        doPop();
        chk("unf pulse", AW'(Underflow), 32'h1);
        chk("unf valid", AW'(TopValid),  32'h0);
        chk("unf top",   TopAddr,        32'h0);
        doIdle();
        chk("unf pulse ends", AW'(Underflow), 32'h0);
        doPush(32'h200);
        chk("after unf push", TopAddr, 32'h200);
        doPop();

        // Push and Pop together, non-empty: replace top
        doPush(32'h300);
        doPush(32'h304);
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
        chk("swap top",       TopAddr,        32'h400);
        chk("swap no ovf",    AW'(Overflow),  32'h0);
        chk("swap no unf",    AW'(Underflow), 32'h0);
        doPop();
        chk("swap second",    TopAddr,        32'h300);
        doPop();

        // Push and Pop together, empty: acts as push
        step(1'b1, 32'h440, 1'b1, 1'b0, 1'b1);
        chk("empty swap top", TopAddr,        32'h440);
        chk("empty swap unf", AW'(Underflow), 32'h0);
        doPop();

        // Flush beats simultaneous push
        doPush(32'h10); doPush(32'h14); doPush(32'h18);
        step(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
        chk("flush valid", AW'(TopValid),  32'h0);
        chk("flush top",   TopAddr,        32'h0);
        chk("flush ovf",   AW'(Overflow),  32'h0);
        chk("flush unf",   AW'(Underflow), 32'h0);
        doPush(32'h600);
        chk("post flush top", TopAddr, 32'h600);
        doPop();

        // Mid-sequence reset with a push presented (must be ignored)
        for (int i = 0; i < 5; i++) doPush(32'h700 + 32'(i));
        step(1'b1, 32'h7FF, 1'b0, 1'b0, 1'b0);
        chk("midrst valid", AW'(TopValid),  32'h0);
        chk("midrst Full",  AW'(Full),      32'h0);
        chk("midrst ovf",   AW'(Overflow),  32'h0);
        chk("midrst unf",   AW'(Underflow), 32'h0);
        doPop();
        chk("midrst pop unf", AW'(Underflow), 32'h1);
        doIdle();

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 32, return-address width in bits.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port Push  input  1  JAL retiring this cycle; push PushAddr.
REQ-006 SHALL have port PushAddr  input  AW  link value (PC+4) written to $31 by JAL.
REQ-007 SHALL have port Pop  input  1  JR $31 retiring this cycle; consume top entry.
REQ-008 SHALL have port Flush  input  1  discard all entries (mispredict/exception recovery).
REQ-009 SHALL have port TopAddr  output  AW  current top entry; predicted return target.
REQ-010 SHALL have port TopValid  output  1  stack non-empty; TopAddr meaningful.
REQ-011 SHALL have port Full  output  1  entry count equals DEPTH.
REQ-012 SHALL have port Overflow  output  1  one-cycle pulse: push dropped the oldest entry.
REQ-013 SHALL have port Underflow  output  1  one-cycle pulse: pop requested while empty.

Function
REQ-014 SHALL store entries in a circular buffer: top pointer (log2 DEPTH bits, wraps modulo DEPTH) plus count (0..DEPTH).
REQ-015 TopAddr, TopValid, Full SHALL be combinational from registered state; TopAddr = entry at top pointer when count>0, else all zeros.
REQ-016 Overflow, Underflow SHALL be registered; asserted exactly one cycle after the causing edge.
REQ-017 Push only: top pointer +1 (wrap), PushAddr written there, count +1 saturating at DEPTH; visible on TopAddr the cycle after.
REQ-018 Push only with Full=1: oldest entry overwritten via wrap, count stays DEPTH, Overflow pulses.
REQ-019 Pop only with count>0: top pointer -1 (wrap), count -1; popped value is TopAddr during the Pop cycle.
REQ-020 Pop only with count=0: no state change, Underflow pulses, TopAddr remains zero.
REQ-021 Push and Pop same cycle, count>0: entry at top pointer replaced by PushAddr; pointer and count unchanged; no pulses.
REQ-022 Push and Pop same cycle, count=0: treated as Push only (count becomes 1); Underflow not asserted.
REQ-023 Flush SHALL take priority over Push/Pop: count <- 0, pointer <- 0, no pulses; entry contents may remain but SHALL never be visible on TopAddr.
REQ-024 Entry storage SHALL be written only on push; no read-modify of other entries.
REQ-025 No handshake back-pressure: every Push/Pop accepted in the cycle presented.

Reset
REQ-026 With Reset_n=0 at a rising edge: count 0, pointer 0, Overflow 0, Underflow 0; Push/Pop/Flush ignored that cycle.
REQ-027 After reset: TopAddr=0, TopValid=0, Full=0; entry storage needs no reset.
REQ-028 Reset asserted mid-sequence (any count) SHALL yield the same post-reset state as power-up.

Verification
REQ-029 Reset, push 0x00400010 then 0x00400020 -> TopAddr=0x00400020, TopValid=1; pop -> next cycle TopAddr=0x00400010; pop -> TopValid=0, TopAddr=0.
REQ-030 DEPTH=8: push 0x100,0x104,...,0x120 (9 pushes) -> Overflow pulses one cycle after 9th, Full=1; 8 pops return 0x120 down to 0x104, then TopValid=0.
REQ-031 Empty, Pop=1 -> Underflow=1 for exactly one cycle, TopValid=0, count unchanged; following Push 0x200 -> TopAddr=0x200.
REQ-032 Stack holding 0x300,0x304: Push 0x400 with Pop same cycle -> TopAddr=0x400, second entry still 0x300 after one pop.
REQ-033 Stack holding 3 entries: Flush with Push 0x500 same cycle -> TopValid=0, TopAddr=0 next cycle, no Overflow/Underflow.
REQ-034 Stack holding 5 entries: Reset_n=0 for one edge -> TopValid=0, Full=0, pulses 0; a following Pop produces Underflow.
